// File: rtl/audio_out_scheduler.sv
// ---------------------------------------------------------------------------
// audio_out_scheduler
//
// Paces 32-bit stereo sample words (L in [31:16], R in [15:0]) from the sound
// DMA requester into the I2S sender, one word per audio frame period. Samples
// are buffered in a small FIFO, a refill request is raised at a low-water
// mark, and silence is inserted on underrun or while muted.
//
// Ports (all logic sampled on posedge in_clk):
//   in_clk        system clock
//   rst_n         synchronous reset, active low
//   enable        1 = start/continue playback, 0 = drain and stop
//   mute          1 = emitted words forced to zero, FIFO still consumed
//   snd_req       refill request to the DMA engine (level)
//   snd_valid     DMA word valid
//   snd_data      DMA sample word
//   snd_ready     FIFO can accept a word (not full)
//   out_valid     one-cycle strobe to the sender's in_valid
//   out_data      word to the sender's in_data, holds last emitted value
//   busy          scheduler is not idle
//   underrun      sticky underrun flag, cleared on reset or on leaving IDLE
//   underrun_cnt  saturating count of silence words inserted by underrun
// ---------------------------------------------------------------------------
module audio_out_scheduler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int LOW_WATER    = 3,
  parameter int PRIME_LEVEL  = 4,
  parameter int FRAME_PERIOD = 512
) (
  input  logic        in_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mute,
  output logic        snd_req,
  input  logic        snd_valid,
  input  logic [31:0] snd_data,
  output logic        snd_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FRAME_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   tick_cnt;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic tc;
  logic pop;

  // Handshake and frame-tick decode. The terminal count only exists while
  // the scheduler is actually pacing words out (RUN or DRAIN); a pop is the
  // terminal count with something buffered, so the FIFO is never popped
  // while empty.
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = snd_valid && !full;
  assign tc    = ((state == RUN) || (state == DRAIN)) &&
                 (tick_cnt == CNT_W'(FRAME_PERIOD - 1));
  assign pop   = tc && !empty;

  // Status outputs are pure decodes of registered state. Refill is only
  // requested while we intend to keep playing, never while idling or draining.
  assign snd_ready = !full;
  assign snd_req   = ((state == PRIME) || (state == RUN)) &&
                     (level <= LVL_W'(LOW_WATER));
  assign busy      = (state != IDLE);

  // Sample storage. Contents need no reset: the pointers and level define
  // what is valid, so a reset flush only has to clear those.
  always_ff @(posedge in_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= snd_data;
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
  // of two; a simultaneous push and pop moves both pointers and leaves the
  // level unchanged.
  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Playback state machine with registered emission outputs. The frame
  // counter is parked at zero outside RUN/DRAIN so that the first word after
  // priming comes out exactly one frame period after entering RUN. At a
  // terminal count the head word (or silence) is latched and strobed on the
  // following cycle. An underrun in RUN still emits a zero word, but drains
  // in DRAIN simply stop when the FIFO is empty.
  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (enable) begin
            state    <= PRIME;
            underrun <= 1'b0;
          end
        end

        PRIME: begin
          tick_cnt <= '0;
          if (!enable) begin
            state <= IDLE;
          end else if (level >= LVL_W'(PRIME_LEVEL)) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (tc) begin
            tick_cnt  <= '0;
            out_valid <= 1'b1;
            if (!empty) begin
              out_data <= mute ? 32'd0 : fifo_mem[rd_ptr];
              state    <= enable ? RUN : DRAIN;
            end else begin
              out_data <= 32'd0;
              underrun <= 1'b1;
              if (underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
              end
              state <= PRIME;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
            if (!enable) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (tc) begin
            tick_cnt <= '0;
            if (!empty) begin
              out_valid <= 1'b1;
              out_data  <= mute ? 32'd0 : fifo_mem[rd_ptr];
              state     <= enable ? RUN : DRAIN;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
            if (enable) begin
              state <= RUN;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
